// File: rtl/sample_serializer.sv
// I2S serializer: mono 16-bit sample duplicated into both 32-bit slots.
// A single-entry holding register decouples the producer strobe from frame timing.
module sample_serializer #(
  parameter int BCLK_HALF = 8
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        enable_in,
  input  logic [15:0] data_in,
  input  logic        data_valid_in,
  output logic        bclk_out,
  output logic        lrclk_out,
  output logic        sdata_out,
  output logic        underrun_out,
  output logic        overrun_out
);

  localparam logic [7:0] DIV_MAX = 8'(BCLK_HALF - 1);

  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_nxt;
  logic [3:0]  idx;
  logic [15:0] hold;
  logic [15:0] shift;
  logic [15:0] samp_nxt;
  logic        full;
  logic        wrap;
  logic        fall;
  logic        frame_start;
  logic        take;
  logic        sdata_nxt;
  logic        lrclk_nxt;

  always_comb begin
    wrap        = enable_in && (div_cnt == DIV_MAX);
    fall        = wrap && bclk_out;
    bit_nxt     = bit_cnt + 6'd1;
    frame_start = fall && (bit_nxt == 6'd0);
    take        = frame_start && full;
    samp_nxt    = take ? hold : shift;
    idx         = 4'd15 - bit_nxt[3:0];
    // slot positions 16..31 and 48..63 carry padding zeros
    sdata_nxt   = bit_nxt[4] ? 1'b0 : samp_nxt[idx];
    lrclk_nxt   = (bit_nxt >= 6'd31) && (bit_nxt != 6'd63);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      div_cnt  <= '0;
      bclk_out <= 1'b0;
    end else if (!enable_in) begin
      div_cnt  <= '0;
      bclk_out <= 1'b0;
    end else if (wrap) begin
      div_cnt  <= '0;
      bclk_out <= ~bclk_out;
    end else begin
      div_cnt  <= div_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      bit_cnt      <= 6'd63;
      lrclk_out    <= 1'b0;
      sdata_out    <= 1'b0;
      shift        <= '0;
      underrun_out <= 1'b0;
    end else if (!enable_in) begin
      bit_cnt      <= 6'd63;
      lrclk_out    <= 1'b0;
      sdata_out    <= 1'b0;
      underrun_out <= 1'b0;
    end else begin
      underrun_out <= frame_start && !full;
      if (fall) begin
        bit_cnt   <= bit_nxt;
        lrclk_out <= lrclk_nxt;
        sdata_out <= sdata_nxt;
        shift     <= samp_nxt;
      end
    end
  end

  // a write landing on the transfer cycle refills the emptied slot
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      hold        <= '0;
      full        <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      overrun_out <= data_valid_in && full && !take;
      if (data_valid_in) begin
        hold <= data_in;
        full <= 1'b1;
      end else if (take) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer at BCLK_HALF=8.
// Frames are captured on bclk rising edges, as an I2S receiver would.
module tb_sample_serializer;

  localparam int BH = 8;
  localparam logic [63:0] EXP_LR = 64'h7FFF_FFFF_8000_0000;

  logic        clk = 1'b0;
  logic        reset_n_in;
  logic        enable_in;
  logic [15:0] data_in;
  logic        data_valid_in;
  logic        bclk_out;
  logic        lrclk_out;
  logic        sdata_out;
  logic        underrun_out;
  logic        overrun_out;

  int checks = 0;
  int failures = 0;

  logic [63:0] cap_bits;
  logic [63:0] cap_lr;
  int          cap_ur;
  int          cap_ov;
  logic        prev_bclk = 1'b0;
  int          since = 0;
  int          w_rise;
  int          w_sd;
  int          w_ur;
  int          w_ur_first;

  sample_serializer #(.BCLK_HALF(BH)) dut (
    .clk_in        (clk),
    .reset_n_in    (reset_n_in),
    .enable_in     (enable_in),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .bclk_out      (bclk_out),
    .lrclk_out     (lrclk_out),
    .sdata_out     (sdata_out),
    .underrun_out  (underrun_out),
    .overrun_out   (overrun_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_bits(input logic [15:0] s);
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) begin
      b[i]      = s[15-i];
      b[32 + i] = s[15-i];
    end
    return b;
  endfunction

  task automatic collect(input int wa, input logic [15:0] da,
                         input int wb, input logic [15:0] db,
                         input bit fs_en, input logic [15:0] fs_d);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    cap_bits = '0;
    cap_lr = '0;
    cap_ur = 0;
    cap_ov = 0;
    while (n < 64 && cyc < 64 * 2 * BH + 64) begin
      @(negedge clk);
      if (bclk_out && !prev_bclk) begin
        cap_bits[n] = sdata_out;
        cap_lr[n] = lrclk_out;
        n++;
        since = 0;
      end else begin
        since++;
      end
      if (underrun_out) cap_ur++;
      if (overrun_out) cap_ov++;
      prev_bclk = bclk_out;
      data_valid_in = 1'b0;
      if (cyc == wa) begin data_valid_in = 1'b1; data_in = da; end
      if (cyc == wb) begin data_valid_in = 1'b1; data_in = db; end
      if (fs_en && n == 0 && since == BH - 1) begin
        data_valid_in = 1'b1;
        data_in = fs_d;
      end
      cyc++;
    end
    if (n < 64) begin
      checks++;
      failures++;
      $display("FAIL collect_timeout: got %0d bits, need 64", n);
    end
  endtask

  task automatic watch(input int n);
    w_rise = 0;
    w_sd = 0;
    w_ur = 0;
    w_ur_first = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (bclk_out && w_rise == 0) w_rise = c;
      if (sdata_out && w_sd == 0) w_sd = c;
      if (underrun_out) begin
        w_ur++;
        if (w_ur_first == 0) w_ur_first = c;
      end
    end
    prev_bclk = bclk_out;
    since = 0;
  endtask

  task automatic check_frame(input string nm, input logic [15:0] s,
                             input int ur, input int ov);
    checks++;
    if (cap_bits !== exp_bits(s)) begin
      failures++;
      $display("FAIL %s_bits: got %h need %h", nm, cap_bits, exp_bits(s));
    end
    checks++;
    if (cap_lr !== EXP_LR) begin
      failures++;
      $display("FAIL %s_lr: got %h need %h", nm, cap_lr, EXP_LR);
    end
    checks++;
    if (cap_ur !== ur) begin
      failures++;
      $display("FAIL %s_underrun: got %0d need %0d", nm, cap_ur, ur);
    end
    checks++;
    if (cap_ov !== ov) begin
      failures++;
      $display("FAIL %s_overrun: got %0d need %0d", nm, cap_ov, ov);
    end
  endtask

  task automatic test_reset();
    reset_n_in = 1'b0;
    enable_in = 1'b0;
    data_valid_in = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bclk_out, lrclk_out, sdata_out, underrun_out, overrun_out} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b need 00000",
               {bclk_out, lrclk_out, sdata_out, underrun_out, overrun_out});
    end
  endtask

  task automatic test_first_frame();
    reset_n_in = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({bclk_out, lrclk_out, sdata_out, underrun_out} !== 4'b0) begin
      failures++;
      $display("FAIL idle_outputs: got %b need 0000",
               {bclk_out, lrclk_out, sdata_out, underrun_out});
    end
    data_valid_in = 1'b1;
    data_in = 16'hA5C3;
    @(negedge clk);
    data_valid_in = 1'b0;
    enable_in = 1'b1;
    watch(2 * BH);
    checks++;
    if (w_rise !== BH) begin
      failures++;
      $display("FAIL first_bclk_rise: got %0d need %0d", w_rise, BH);
    end
    checks++;
    if (w_sd !== 2 * BH) begin
      failures++;
      $display("FAIL first_frame_start: got %0d need %0d", w_sd, 2 * BH);
    end
    checks++;
    if (w_ur !== 0) begin
      failures++;
      $display("FAIL first_underrun: got %0d need 0", w_ur);
    end
    collect(-1, '0, -1, '0, 1'b0, '0);
    check_frame("a5c3", 16'hA5C3, 0, 0);
  endtask

  task automatic test_underrun();
    collect(-1, '0, -1, '0, 1'b0, '0);
    check_frame("replay1", 16'hA5C3, 1, 0);
    collect(-1, '0, -1, '0, 1'b0, '0);
    check_frame("replay2", 16'hA5C3, 1, 0);
  endtask

  task automatic test_overrun();
    collect(10, 16'h1234, 50, 16'h8000, 1'b0, '0);
    check_frame("ovr_frame", 16'hA5C3, 1, 1);
    collect(-1, '0, -1, '0, 1'b0, '0);
    check_frame("ovr_next", 16'h8000, 0, 0);
  endtask

  task automatic test_back_to_back();
    collect(100, 16'h0001, -1, '0, 1'b0, '0);
    check_frame("b2b_fill", 16'h8000, 1, 0);
    collect(-1, '0, -1, '0, 1'b1, 16'h7FFF);
    check_frame("b2b_old", 16'h0001, 0, 0);
    collect(-1, '0, -1, '0, 1'b0, '0);
    check_frame("b2b_new", 16'h7FFF, 0, 0);
  endtask

  task automatic test_lr_period();
    logic pl;
    logic pb;
    int c;
    bit seen;
    pl = lrclk_out;
    pb = bclk_out;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (lrclk_out && !pl) begin
        seen = 1'b1;
        checks++;
        if (!(pb && !bclk_out)) begin
          failures++;
          $display("FAIL lr_on_bclk_fall: bclk %b->%b need 1->0", pb, bclk_out);
        end
      end
      pl = lrclk_out;
      pb = bclk_out;
    end
    c = 0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      c++;
      if (lrclk_out && !pl) seen = 1'b1;
      pl = lrclk_out;
    end
    checks++;
    if (c !== 64 * 2 * BH) begin
      failures++;
      $display("FAIL lr_period: got %0d need %0d", c, 64 * 2 * BH);
    end
  endtask

  task automatic test_disable();
    @(negedge clk);
    enable_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({bclk_out, lrclk_out, sdata_out} !== 3'b0) begin
      failures++;
      $display("FAIL disable_outputs: got %b need 000",
               {bclk_out, lrclk_out, sdata_out});
    end
    data_valid_in = 1'b1;
    data_in = 16'h1111;
    @(negedge clk);
    data_in = 16'hC000;
    @(negedge clk);
    checks++;
    if (overrun_out !== 1'b1) begin
      failures++;
      $display("FAIL disabled_overrun: got %b need 1", overrun_out);
    end
    data_valid_in = 1'b0;
    enable_in = 1'b1;
    watch(2 * BH);
    checks++;
    if (w_rise !== BH || w_sd !== 2 * BH || w_ur !== 0) begin
      failures++;
      $display("FAIL reenable_timing: rise %0d sd %0d ur %0d need %0d %0d 0",
               w_rise, w_sd, w_ur, BH, 2 * BH);
    end
    collect(-1, '0, -1, '0, 1'b0, '0);
    check_frame("reenable", 16'hC000, 0, 0);
  endtask

  task automatic test_reset_mid();
    logic pl;
    bit seen;
    pl = lrclk_out;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (lrclk_out && !pl) seen = 1'b1;
      pl = lrclk_out;
    end
    repeat (100) @(negedge clk);
    data_valid_in = 1'b1;
    data_in = 16'h5555;
    @(negedge clk);
    data_valid_in = 1'b0;
    checks++;
    if (lrclk_out !== 1'b1) begin
      failures++;
      $display("FAIL mid_right_slot: lrclk %b need 1", lrclk_out);
    end
    #2 reset_n_in = 1'b0;
    #1;
    checks++;
    if ({bclk_out, lrclk_out, sdata_out, underrun_out, overrun_out} !== 5'b0) begin
      failures++;
      $display("FAIL async_reset: got %b need 00000",
               {bclk_out, lrclk_out, sdata_out, underrun_out, overrun_out});
    end
    @(negedge clk);
    reset_n_in = 1'b1;
    watch(2 * BH);
    checks++;
    if (w_rise !== BH || w_ur_first !== 2 * BH || w_ur !== 1) begin
      failures++;
      $display("FAIL restart_timing: rise %0d ur_at %0d ur %0d need %0d %0d 1",
               w_rise, w_ur_first, w_ur, BH, 2 * BH);
    end
    collect(-1, '0, -1, '0, 1'b0, '0);
    check_frame("post_reset", 16'h0000, 0, 0);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_underrun();
    test_overrun();
    test_back_to_back();
    test_lr_period();
    test_disable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
